pu_sequencer: RTL and testbench
===============================

Name: pu_sequencer

Overview:
- Upstream control and operand stage for the 4-input processing unit (PU).
- Accepts one operand set per transaction: four 5-bit inputs plus four 5-bit weights, over a valid/ready handshake.
- Holds the operands on the PU inputs and issues the multiply-register and sum-register enables in order.
- Captures the PU activation output and its nonzero flag, and presents them downstream on a second valid/ready handshake. Also keeps a saturating count of nonzero results.

Parameters:
- CNT_W, 8, width of the nonzero-result counter nz_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set on in_x/in_w is valid.
- in_ready  output  1  block accepts an operand set this cycle.
- in_x  input  20  packed inputs: [4:0]=x1, [9:5]=x2, [14:10]=x3, [19:15]=x4.
- in_w  input  20  packed weights, same packing as in_x.
- x1, x2, x3, x4  output  5 each  registered inputs driven to the PU.
- w1, w2, w3, w4  output  5 each  registered weights driven to the PU.
- mul_en  output  1  load enable for the PU product registers.
- sum_en  output  1  load enable for the PU sum register.
- pu_out  input  5  PU activation output.
- pu_s  input  1  PU nonzero flag.
- out_valid  output  1  result on out_data/out_s is valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  5  captured activation value.
- out_s  output  1  captured nonzero flag.
- busy  output  1  high in every state except IDLE.
- clr_cnt  input  1  synchronous clear of nz_count.
- nz_count  output  CNT_W  count of results with pu_s=1, saturating.

Behaviour:
- Reset (rst=0, asynchronous) forces state to IDLE. All registered outputs go to 0: x1..x4, w1..w4, out_data, out_s, nz_count. All control outputs go low: mul_en, sum_en, out_valid, busy.
- Reset mid-transaction abandons the transaction. There is no output pulse and no counter update.
- States and transitions:
  - IDLE: in_ready=1. On in_valid=1, the edge loads in_x/in_w into the operand registers and moves to MUL.
  - MUL: mul_en=1 for exactly this cycle; operand registers hold. Next state SUM.
  - SUM: sum_en=1 for exactly this cycle. Next state CAP.
  - CAP: the edge loads pu_out into out_data and pu_s into out_s. If pu_s=1, nz_count increments. Next state OUT.
  - OUT: out_valid=1; out_data/out_s are held stable until out_ready=1.
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=1 and in_valid=1: same-cycle accept. in_ready=1, the new operands load, and the next state is MUL.
    - out_ready=0: in_ready=0 and the block stays in OUT.
- in_ready is a combinational output: (state==IDLE) || (state==OUT && out_ready).
- mul_en and sum_en are decoded from registered state only: glitch-free and never high together.
- Latency: an operand set accepted at edge E0 gives mul_en high in the following cycle, sum_en high in the one after, CAP in the third, and out_valid high in the fourth cycle after E0.
- Minimum issue interval under continuous in_valid/out_ready is 4 cycles.
- Operand registers change only on an accepted handshake. They hold through MUL, SUM, CAP and OUT.
- nz_count saturates at 2^CNT_W-1. clr_cnt=1 sets it to 0 on the next edge and wins over a simultaneous increment.
- in_valid in MUL/SUM/CAP is ignored: no accept, and upstream must hold its data.
- out_ready outside OUT has no effect.

Test Plan:
- Reset, then a single vector: in_x={4,3,2,1}, in_w={1,1,1,1}, in_valid held one cycle.
  - During MUL: x1..x4=1,2,3,4, w1..w4=1, mul_en=1.
  - Next cycle: sum_en=1.
  - Bench PU model returns pu_out=10, pu_s=1 in CAP.
  - Result: out_valid=1 with out_data=10, out_s=1, nz_count=1.
- Backpressure: hold out_ready=0 for 5 cycles in OUT.
  - out_valid stays 1, out_data stays 10, in_ready stays 0.
  - Raise out_ready with in_valid=0: block goes to IDLE, busy=0.
- Back-to-back: in_valid=1 and out_ready=1 continuously for 3 vectors.
  - in_ready pulses once every 4 cycles.
  - mul_en cycles are exactly 4 apart.
  - Each result matches its own operand set.
- Zero result: pu_out=0, pu_s=0.
  - out_s=0 and nz_count is unchanged.
- Counter: with CNT_W=2, run 4 results with pu_s=1.
  - nz_count reads 1, 2, 3, 3 (saturated).
  - Then assert clr_cnt in the same cycle as a CAP with pu_s=1: nz_count=0.
- Asynchronous reset: drop rst in the SUM cycle between clock edges.
  - Immediately: sum_en=0, busy=0, x1..x4=0.
  - After release, a new vector completes normally.

Source files
------------

// File: rtl/pu_sequencer.sv
// Operand/control sequencer for the 4-input processing unit: accepts an operand set,
// steps the PU through multiply and sum, then hands the activation result downstream.
module pu_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [19:0]      in_x,
  input  logic [19:0]      in_w,
  output logic [4:0]       x1,
  output logic [4:0]       x2,
  output logic [4:0]       x3,
  output logic [4:0]       x4,
  output logic [4:0]       w1,
  output logic [4:0]       w2,
  output logic [4:0]       w3,
  output logic [4:0]       w4,
  output logic             mul_en,
  output logic             sum_en,
  input  logic [4:0]       pu_out,
  input  logic             pu_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_data,
  output logic             out_s,
  output logic             busy,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] nz_count
);

  typedef enum logic [2:0] {IDLE, MUL, SUM, CAP, OUT} state_t;

  state_t state_q, state_d;
  logic   accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = MUL;
      end
      MUL: state_d = SUM;
      SUM: state_d = CAP;
      CAP: state_d = OUT;
      OUT: begin
        // Same-cycle hand-off: a waiting operand set is taken as the result leaves.
        if (out_ready) begin
          in_ready = 1'b1;
          state_d  = in_valid ? MUL : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign mul_en    = (state_q == MUL);
  assign sum_en    = (state_q == SUM);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);

  // Stage p0: operand capture on the input handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {x4, x3, x2, x1} <= '0;
      {w4, w3, w2, w1} <= '0;
    end else if (accept) begin
      {x4, x3, x2, x1} <= in_x;
      {w4, w3, w2, w1} <= in_w;
    end
  end

  // Stage p1: result capture and nonzero tally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data <= '0;
      out_s    <= 1'b0;
      nz_count <= '0;
    end else begin
      if (state_q == CAP) begin
        out_data <= pu_out;
        out_s    <= pu_s;
      end
      if (clr_cnt)
        nz_count <= '0;
      else if (state_q == CAP && pu_s)
        nz_count <= sat_inc(nz_count);
    end
  end

endmodule

// File: tb/tb_pu_sequencer.sv
// Directed bench for pu_sequencer with a small registered PU model (products on mul_en,
// saturated sum on sum_en).
module tb_pu_sequencer;

  localparam int CNT_W = 2;

  logic             clk, rst;
  logic             in_valid, in_ready;
  logic [19:0]      in_x, in_w;
  logic [4:0]       x1, x2, x3, x4, w1, w2, w3, w4;
  logic             mul_en, sum_en;
  logic [4:0]       pu_out;
  logic             pu_s;
  logic             out_valid, out_ready;
  logic [4:0]       out_data;
  logic             out_s, busy, clr_cnt;
  logic [CNT_W-1:0] nz_count;

  pu_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_w(in_w),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4), .w1(w1), .w2(w2), .w3(w3), .w4(w4),
    .mul_en(mul_en), .sum_en(sum_en), .pu_out(pu_out), .pu_s(pu_s),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_s(out_s),
    .busy(busy), .clr_cnt(clr_cnt), .nz_count(nz_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  prod [4];
  logic [11:0] sumr;

  always @(posedge clk) begin
    if (mul_en) begin
      prod[0] <= x1 * w1;
      prod[1] <= x2 * w2;
      prod[2] <= x3 * w3;
      prod[3] <= x4 * w4;
    end
    if (sum_en) sumr <= 12'(prod[0]) + 12'(prod[1]) + 12'(prod[2]) + 12'(prod[3]);
  end

  assign pu_out = (sumr > 12'd31) ? 5'd31 : sumr[4:0];
  assign pu_s   = (pu_out != 5'd0);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [19:0] x;
    logic [19:0] w;
    logic [4:0]  exp_out;
    logic        exp_s;
    logic [1:0]  exp_cnt;
    int          stall;
  } vec_t;

  task automatic run_txn(input vec_t v);
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    in_valid = 1'b1; in_x = v.x; in_w = v.w;
    @(negedge clk);
    in_x = ~v.x; in_w = ~v.w;
    chk("mul_en", mul_en, 1);
    chk("mul_sum_en", sum_en, 0);
    chk("mul_in_ready", in_ready, 0);
    chk("mul_x", {x4, x3, x2, x1}, v.x);
    chk("mul_w", {w4, w3, w2, w1}, v.w);
    @(negedge clk);
    chk("sum_en", sum_en, 1);
    chk("sum_mul_en", mul_en, 0);
    chk("sum_x_hold", {x4, x3, x2, x1}, v.x);
    @(negedge clk);
    chk("cap_out_valid", out_valid, 0);
    chk("cap_en", {mul_en, sum_en}, 0);
    chk("cap_busy", busy, 1);
    @(negedge clk);
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, v.exp_out);
    chk("out_s", out_s, v.exp_s);
    chk("nz_count", nz_count, v.exp_cnt);
    for (int i = 0; i < v.stall; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, v.exp_out);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_x_hold", {x4, x3, x2, x1}, v.x);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rel_busy", busy, 0);
    chk("rel_out_valid", out_valid, 0);
    out_ready = 1'b0;
  endtask

  vec_t tbl [5];
  vec_t b2b [3];

  initial begin
    // packing {x4,x3,x2,x1}
    tbl[0] = '{ {5'd4, 5'd3, 5'd2, 5'd1}, {5'd1, 5'd1, 5'd1, 5'd1}, 5'd10, 1'b1, 2'd1, 5 };
    tbl[1] = '{ {5'd1, 5'd5, 5'd0, 5'd2}, {5'd2, 5'd1, 5'd7, 5'd3}, 5'd13, 1'b1, 2'd2, 0 };
    tbl[2] = '{ {5'd0, 5'd0, 5'd0, 5'd0}, {5'd9, 5'd9, 5'd9, 5'd9}, 5'd0,  1'b0, 2'd2, 1 };
    tbl[3] = '{ {5'd31, 5'd31, 5'd31, 5'd31}, {5'd31, 5'd31, 5'd31, 5'd31}, 5'd31, 1'b1, 2'd3, 0 };
    tbl[4] = '{ {5'd1, 5'd1, 5'd1, 5'd1}, {5'd4, 5'd3, 5'd2, 5'd1}, 5'd10, 1'b1, 2'd3, 0 };
    b2b[0] = '{ {5'd3, 5'd3, 5'd3, 5'd3}, {5'd1, 5'd1, 5'd1, 5'd1}, 5'd12, 1'b1, 2'd3, 0 };
    b2b[1] = '{ {5'd0, 5'd0, 5'd0, 5'd5}, {5'd2, 5'd2, 5'd2, 5'd2}, 5'd10, 1'b1, 2'd3, 0 };
    b2b[2] = '{ {5'd0, 5'd6, 5'd0, 5'd0}, {5'd0, 5'd0, 5'd0, 5'd0}, 5'd0,  1'b0, 2'd3, 0 };

    rst = 1'b0; in_valid = 1'b0; in_x = '0; in_w = '0; out_ready = 1'b0; clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {mul_en, sum_en, out_valid, busy}, 0);
    chk("rst_ops", {x4, x3, x2, x1, w4, w3, w2, w1}, 0);
    chk("rst_out", {out_data, out_s}, 0);
    chk("rst_cnt", nz_count, 0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) run_txn(tbl[i]);

    // Back-to-back: accept every 4 cycles, mul_en 4 apart
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; in_x = b2b[0].x; in_w = b2b[0].w;
    chk("b2b_in_ready0", in_ready, 1);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      chk("b2b_in_ready", in_ready, (n % 4 == 0) ? 1 : 0);
      chk("b2b_mul_en", mul_en, (n % 4 == 1) ? 1 : 0);
      if (n % 4 == 1) chk("b2b_x", {x4, x3, x2, x1}, b2b[n / 4].x);
      if (n % 4 == 0) begin
        chk("b2b_out_valid", out_valid, 1);
        chk("b2b_out_data", out_data, b2b[n / 4 - 1].exp_out);
        chk("b2b_out_s", out_s, b2b[n / 4 - 1].exp_s);
        if (n < 12) begin
          in_x = b2b[n / 4].x; in_w = b2b[n / 4].w;
        end else in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_idle", busy, 0);
    out_ready = 1'b0;

    // clr_cnt wins over a simultaneous increment
    in_valid = 1'b1; in_x = {5'd1, 5'd1, 5'd1, 5'd1}; in_w = {5'd1, 5'd1, 5'd1, 5'd1};
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clr_out_data", out_data, 4);
    chk("clr_out_s", out_s, 1);
    chk("clr_cnt", nz_count, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("clr_idle", busy, 0);

    // Asynchronous reset in the SUM cycle
    in_valid = 1'b1; in_x = {5'd2, 5'd2, 5'd2, 5'd2}; in_w = {5'd1, 5'd1, 5'd1, 5'd1};
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("arst_pre_sum", sum_en, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_sum_en", sum_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_x", {x4, x3, x2, x1}, 0);
    chk("arst_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    run_txn('{ {5'd1, 5'd5, 5'd0, 5'd2}, {5'd2, 5'd1, 5'd7, 5'd3}, 5'd13, 1'b1, 2'd1, 0 });

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
